// File: rtl/mem_bus_arbiter_if.sv
// Request, response and shared-bus signals between fetch, memory stage
// and the memory bus. The slave modport is the arbiter's view.
interface mem_bus_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic [2:0]  i_size;
  logic        i_ok;
  logic [63:0] i_rdata;

  logic        d_valid;
  logic        d_write;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_ok;
  logic [63:0] d_rdata;

  logic        bus_valid;
  logic        bus_write;
  logic [63:0] bus_addr;
  logic [2:0]  bus_size;
  logic [7:0]  bus_strobe;
  logic [63:0] bus_wdata;
  logic        bus_ok;
  logic [63:0] bus_rdata;

  modport slave (
    input  i_valid, i_addr, i_size,
    input  d_valid, d_write, d_addr,
    input  d_size, d_strobe, d_wdata,
    input  bus_ok, bus_rdata,
    output i_ok, i_rdata,
    output d_ok, d_rdata,
    output bus_valid, bus_write,
    output bus_addr, bus_size,
    output bus_strobe, bus_wdata
  );

  modport master (
    output i_valid, i_addr, i_size,
    output d_valid, d_write, d_addr,
    output d_size, d_strobe, d_wdata,
    output bus_ok, bus_rdata,
    input  i_ok, i_rdata,
    input  d_ok, d_rdata,
    input  bus_valid, bus_write,
    input  bus_addr, bus_size,
    input  bus_strobe, bus_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter of the memory bus between fetch (I) and
// memory stage (D); D has priority, with a starvation escape for I.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave mb
);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          valid_q, valid_d;
  logic          write_q, write_d;
  logic [63:0]   addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [7:0]    strobe_q, strobe_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          grant_d, grant_i;
  logic          i_hit, d_hit;

  always_comb begin
    // I only wins a contested IDLE cycle once D has starved it
    grant_d = mb.d_valid &&
      !(mb.i_valid && starve_cnt_q == LIM);
    grant_i = mb.i_valid && !grant_d;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    valid_d      = valid_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = BUSY_D;
          valid_d  = 1'b1;
          write_d  = mb.d_write;
          addr_d   = mb.d_addr;
          size_d   = mb.d_size;
          strobe_d = mb.d_strobe;
          wdata_d  = mb.d_wdata;
          if (mb.i_valid && starve_cnt_q != LIM)
            starve_cnt_d = starve_cnt_q + CW'(1);
        end else if (grant_i) begin
          state_d      = BUSY_I;
          valid_d      = 1'b1;
          write_d      = 1'b0;
          addr_d       = mb.i_addr;
          size_d       = mb.i_size;
          strobe_d     = '0;
          wdata_d      = '0;
          starve_cnt_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mb.bus_ok) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      valid_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      strobe_q     <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      valid_q      <= valid_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      strobe_q     <= strobe_d;
      wdata_q      <= wdata_d;
    end
  end

  // Completion is passed straight through to the owner
  assign i_hit = (state_q == BUSY_I) && mb.bus_ok;
  assign d_hit = (state_q == BUSY_D) && mb.bus_ok;

  assign mb.i_ok    = i_hit;
  assign mb.d_ok    = d_hit;
  assign mb.i_rdata = i_hit ? mb.bus_rdata : '0;
  assign mb.d_rdata = d_hit ? mb.bus_rdata : '0;

  assign mb.bus_valid  = valid_q;
  assign mb.bus_write  = write_q;
  assign mb.bus_addr   = addr_q;
  assign mb.bus_size   = size_q;
  assign mb.bus_strobe = strobe_q;
  assign mb.bus_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a
// request-level reference model of its arbitration rules.
module tb_mem_bus_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_bus_arbiter_if mb();

  mem_bus_arbiter #(
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mb   (mb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mb.i_valid   = 1'b0;
    mb.i_addr    = '0;
    mb.i_size    = '0;
    mb.d_valid   = 1'b0;
    mb.d_write   = 1'b0;
    mb.d_addr    = '0;
    mb.d_size    = '0;
    mb.d_strobe  = '0;
    mb.d_wdata   = '0;
    mb.bus_ok    = 1'b0;
    mb.bus_rdata = '0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_bv"}, mb.bus_valid, 0);
    chk({tag, "_bw"}, mb.bus_write, 0);
    chk({tag, "_ba"}, mb.bus_addr, 0);
    chk({tag, "_bsz"}, mb.bus_size, 0);
    chk({tag, "_bst"}, mb.bus_strobe, 0);
    chk({tag, "_bwd"}, mb.bus_wdata, 0);
    chk({tag, "_iok"}, mb.i_ok, 0);
    chk({tag, "_dok"}, mb.d_ok, 0);
    chk({tag, "_ird"}, mb.i_rdata, 0);
    chk({tag, "_drd"}, mb.d_rdata, 0);
  endtask

  int          nd;
  bit          got_i;
  int          m_owner;
  int          m_starve;
  bit          ip, dp, gd;
  logic [63:0] ia, da, dwd, rd;
  logic [2:0]  isz, dsz;
  logic [7:0]  dst;
  bit          dw;
  logic [63:0] e_addr, e_wdata;
  logic [2:0]  e_size;
  logic [7:0]  e_strobe;
  bit          e_write;

  initial begin
    idle_inputs();
    mb.bus_ok = 1'b1;
    mb.bus_rdata = 64'h1234;
    #2 reset = 1'b1;
    #10;
    outs_zero("reset");
    cyc();
    reset = 1'b0;
    mb.bus_ok = 1'b0;
    cyc();

    // single instruction fetch
    mb.i_valid = 1'b1;
    mb.i_addr  = 64'h8000_0000;
    mb.i_size  = 3'd2;
    #1;
    chk("t1_pre_bv", mb.bus_valid, 0);
    cyc();
    chk("t1_bv", mb.bus_valid, 1);
    chk("t1_bw", mb.bus_write, 0);
    chk("t1_bst", mb.bus_strobe, 0);
    chk("t1_bwd", mb.bus_wdata, 0);
    chk("t1_ba", mb.bus_addr, 64'h8000_0000);
    chk("t1_bsz", mb.bus_size, 2);
    chk("t1_iok_early", mb.i_ok, 0);
    cyc();
    chk("t1_iok_wait", mb.i_ok, 0);
    cyc();
    mb.bus_ok = 1'b1;
    mb.bus_rdata = 64'h13;
    #1;
    chk("t1_iok", mb.i_ok, 1);
    chk("t1_ird", mb.i_rdata, 64'h13);
    chk("t1_dok", mb.d_ok, 0);
    chk("t1_drd", mb.d_rdata, 0);
    cyc();
    idle_inputs();
    #1;
    chk("t1_iok_after", mb.i_ok, 0);
    chk("t1_bv_after", mb.bus_valid, 0);

    // store with stable fields across BUSY
    mb.d_valid  = 1'b1;
    mb.d_write  = 1'b1;
    mb.d_addr   = 64'h8000_1000;
    mb.d_size   = 3'd3;
    mb.d_strobe = 8'hFF;
    mb.d_wdata  = 64'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t2_bv", mb.bus_valid, 1);
      chk("t2_bw", mb.bus_write, 1);
      chk("t2_ba", mb.bus_addr, 64'h8000_1000);
      chk("t2_bsz", mb.bus_size, 3);
      chk("t2_bst", mb.bus_strobe, 8'hFF);
      chk("t2_bwd", mb.bus_wdata, 64'hDEAD_BEEF);
      chk("t2_dok_wait", mb.d_ok, 0);
    end
    mb.bus_ok = 1'b1;
    mb.bus_rdata = 64'h55AA;
    #1;
    chk("t2_dok", mb.d_ok, 1);
    chk("t2_drd", mb.d_rdata, 64'h55AA);
    chk("t2_iok", mb.i_ok, 0);
    cyc();
    idle_inputs();
    #1;
    chk("t2_bv_after", mb.bus_valid, 0);

    // contention: D first, one IDLE cycle, then I
    mb.i_valid = 1'b1;
    mb.i_addr  = 64'hA000;
    mb.i_size  = 3'd2;
    mb.d_valid = 1'b1;
    mb.d_addr  = 64'hB000;
    mb.d_size  = 3'd3;
    cyc();
    chk("t3_bv_d", mb.bus_valid, 1);
    chk("t3_ba_d", mb.bus_addr, 64'hB000);
    mb.bus_ok = 1'b1;
    mb.bus_rdata = 64'h77;
    #1;
    chk("t3_dok", mb.d_ok, 1);
    chk("t3_iok_no", mb.i_ok, 0);
    cyc();
    mb.d_valid = 1'b0;
    mb.bus_ok = 1'b0;
    #1;
    chk("t3_gap_bv", mb.bus_valid, 0);
    cyc();
    chk("t3_bv_i", mb.bus_valid, 1);
    chk("t3_ba_i", mb.bus_addr, 64'hA000);
    chk("t3_bst_i", mb.bus_strobe, 0);
    mb.bus_ok = 1'b1;
    #1;
    chk("t3_iok", mb.i_ok, 1);
    cyc();
    idle_inputs();

    // starvation: I waits behind a steady D stream
    mb.i_valid = 1'b1;
    mb.i_addr  = 64'h1000;
    mb.d_valid = 1'b1;
    mb.d_addr  = 64'h2000;
    nd = 0;
    got_i = 1'b0;
    for (int c = 0; c < 40 && !got_i; c++) begin
      cyc();
      mb.bus_ok = mb.bus_valid;
      mb.bus_rdata = 64'(c);
      #1;
      if (mb.bus_valid) begin
        if (mb.bus_addr == 64'h1000) got_i = 1'b1;
        else nd++;
      end
    end
    chk("t4_i_granted", got_i, 1);
    chk("t4_d_grants", nd, LIMIT);
    cyc();
    idle_inputs();
    #1;
    chk("t4_cnt_clear", dut.starve_cnt_q, 0);

    // reset in the middle of a D transaction
    mb.d_valid  = 1'b1;
    mb.d_write  = 1'b1;
    mb.d_addr   = 64'h3000;
    mb.d_strobe = 8'h0F;
    mb.d_wdata  = 64'h99;
    cyc();
    chk("t5_bv", mb.bus_valid, 1);
    reset = 1'b1;
    mb.bus_ok = 1'b1;
    #1;
    outs_zero("t5_rst");
    cyc();
    reset = 1'b0;
    mb.d_valid = 1'b0;
    #1;
    chk("t5_late_dok", mb.d_ok, 0);
    chk("t5_late_iok", mb.i_ok, 0);
    cyc();
    idle_inputs();
    mb.i_valid = 1'b1;
    mb.i_addr  = 64'h4000;
    #1;
    chk("t5_idle_bv", mb.bus_valid, 0);
    cyc();
    chk("t5_i_bv", mb.bus_valid, 1);
    chk("t5_i_ba", mb.bus_addr, 64'h4000);
    mb.bus_ok = 1'b1;
    #1;
    chk("t5_i_ok", mb.i_ok, 1);
    cyc();
    idle_inputs();

    // stray bus_ok in IDLE, then d_valid dropped mid-BUSY
    mb.bus_ok = 1'b1;
    #1;
    chk("t6_stray_iok", mb.i_ok, 0);
    chk("t6_stray_dok", mb.d_ok, 0);
    cyc();
    mb.bus_ok = 1'b0;
    chk("t6_stray_bv", mb.bus_valid, 0);
    mb.d_valid = 1'b1;
    mb.d_addr  = 64'h5000;
    cyc();
    chk("t6_bv", mb.bus_valid, 1);
    mb.d_valid = 1'b0;
    cyc();
    chk("t6_bv_held", mb.bus_valid, 1);
    chk("t6_ba_held", mb.bus_addr, 64'h5000);
    mb.bus_ok = 1'b1;
    mb.bus_rdata = 64'hC0DE;
    #1;
    chk("t6_dok", mb.d_ok, 1);
    chk("t6_drd", mb.d_rdata, 64'hC0DE);
    cyc();
    idle_inputs();
    #1;
    chk("t6_bv_after", mb.bus_valid, 0);

    // randomized traffic vs request-level model
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_owner = 0;
    m_starve = 0;
    ip = 1'b0;
    dp = 1'b0;
    for (int c = 0; c < 800; c++) begin
      cyc();
      chk("r_bv", mb.bus_valid, m_owner != 0);
      if (m_owner != 0) begin
        chk("r_ba", mb.bus_addr, e_addr);
        chk("r_bsz", mb.bus_size, e_size);
        chk("r_bw", mb.bus_write, e_write);
        chk("r_bst", mb.bus_strobe, e_strobe);
        chk("r_bwd", mb.bus_wdata, e_wdata);
      end
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip  = 1'b1;
        ia  = {$urandom, $urandom};
        isz = 3'($urandom_range(0, 3));
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp  = 1'b1;
        da  = {$urandom, $urandom};
        dsz = 3'($urandom_range(0, 3));
        dw  = 1'($urandom);
        dst = 8'($urandom);
        dwd = {$urandom, $urandom};
      end
      mb.i_valid  = ip;
      mb.i_addr   = ia;
      mb.i_size   = isz;
      mb.d_valid  = dp;
      mb.d_write  = dw;
      mb.d_addr   = da;
      mb.d_size   = dsz;
      mb.d_strobe = dst;
      mb.d_wdata  = dwd;
      if (m_owner != 0)
        mb.bus_ok = ($urandom_range(0, 2) == 0);
      else
        mb.bus_ok = ($urandom_range(0, 7) == 0);
      rd = {$urandom, $urandom};
      mb.bus_rdata = rd;
      #1;
      chk("r_iok", mb.i_ok, m_owner == 1 && mb.bus_ok);
      chk("r_ird",
          mb.i_rdata, (m_owner == 1 && mb.bus_ok) ? rd : 64'h0);
      chk("r_dok", mb.d_ok, m_owner == 2 && mb.bus_ok);
      chk("r_drd",
          mb.d_rdata, (m_owner == 2 && mb.bus_ok) ? rd : 64'h0);
      if (m_owner != 0) begin
        if (mb.bus_ok) begin
          if (m_owner == 1) ip = 1'b0;
          else dp = 1'b0;
          m_owner = 0;
        end
      end else begin
        gd = dp && !(ip && m_starve == LIMIT);
        if (gd) begin
          m_owner  = 2;
          e_addr   = da;
          e_size   = dsz;
          e_write  = dw;
          e_strobe = dst;
          e_wdata  = dwd;
          if (ip && m_starve < LIMIT) m_starve++;
        end else if (ip) begin
          m_owner  = 1;
          e_addr   = ia;
          e_size   = isz;
          e_write  = 1'b0;
          e_strobe = '0;
          e_wdata  = '0;
          m_starve = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
